// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: buffered UART controller on the J1 I/O bus.
// 8-deep TX/RX FIFOs, data/status/flush registers, TX FSM, irq.
// Ports:
//   clk, resetq                 clock, async active-low reset
//   io_rd, io_wr, io_addr       CPU strobes and address
//   io_dout / io_din            CPU write data / read data
//   uart0_wr, uart_w            TX byte strobe and byte to UART core
//   uart0_busy                  UART transmitter busy
//   uart0_rd                    RX ack strobe to UART core
//   uart0_valid, uart0_data     UART received byte
//   irq                         RX non-empty or (tx_ie and TX empty)
module uart_io_ctrl #(
    parameter int TX_AW    = 3,
    parameter int RX_AW    = 3,
    parameter int DATA_BIT = 12,
    parameter int STAT_BIT = 13
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        uart0_wr,
    output logic [7:0]  uart_w,
    input  logic        uart0_busy,
    output logic        uart0_rd,
    input  logic        uart0_valid,
    input  logic [7:0]  uart0_data,
    output logic        irq
);

    localparam int TXD = 1 << TX_AW;
    localparam int RXD = 1 << RX_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t         r_state;
    logic [7:0]     r_tx_mem [TXD];
    logic [7:0]     r_rx_mem [RXD];
    logic [TX_AW:0] r_tx_wp, r_tx_rp;
    logic [RX_AW:0] r_rx_wp, r_rx_rp;
    logic           r_tx_drop, r_tx_ie;
    logic           r_uart_wr, r_uart_rd, r_rx_hold;
    logic [7:0]     r_uart_w;
    logic           r_irq;

    logic           w_data_wr, w_stat_wr, w_stat_rd, w_flush;
    logic           w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic           w_tx_push, w_tx_drop, w_tx_pop;
    logic           w_rx_push, w_rx_pop, w_tx_idle;
    logic [TX_AW:0] w_tx_cnt;
    logic [RX_AW:0] w_rx_cnt;
    logic [15:0]    w_tx_c16, w_rx_c16;
    logic [3:0]     w_tx_c4, w_rx_c4;
    logic [15:0]    w_status;
    logic           w_unused;

    // DATA decode has priority when both address bits are set
    assign w_data_wr = io_wr & io_addr[DATA_BIT];
    assign w_stat_wr = io_wr & io_addr[STAT_BIT] & ~io_addr[DATA_BIT];
    assign w_stat_rd = io_rd & io_addr[STAT_BIT] & ~io_addr[DATA_BIT];
    assign w_flush   = w_stat_wr & io_dout[15];

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                        (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                        (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);

    // full is judged on cycle-start state, so a same-cycle drain
    // pop does not rescue a write into a full FIFO
    assign w_tx_push = w_data_wr & ~w_tx_full & ~w_flush;
    assign w_tx_drop = w_data_wr & w_tx_full;
    assign w_tx_pop  = (r_state == S_IDLE) & ~w_tx_empty &
                       ~uart0_busy & ~w_flush;

    // no capture while acking or in the cycle after the ack,
    // since the core's valid may still reflect the old byte
    assign w_rx_push = uart0_valid & ~w_rx_full & ~r_uart_rd &
                       ~r_rx_hold & ~w_flush;
    assign w_rx_pop  = io_rd & io_addr[DATA_BIT] & ~w_rx_empty &
                       ~w_flush;

    assign w_tx_idle = w_tx_empty & (r_state == S_IDLE) & ~uart0_busy;

    assign w_tx_cnt = r_tx_wp - r_tx_rp;
    assign w_rx_cnt = r_rx_wp - r_rx_rp;
    assign w_tx_c16 = 16'(w_tx_cnt);
    assign w_rx_c16 = 16'(w_rx_cnt);
    assign w_tx_c4  = (w_tx_c16 > 16'd15) ? 4'hF : w_tx_c16[3:0];
    assign w_rx_c4  = (w_rx_c16 > 16'd15) ? 4'hF : w_rx_c16[3:0];

    assign w_status = {w_tx_c4, w_rx_c4, 3'b000, r_tx_ie, r_tx_drop,
                       w_tx_idle, ~w_tx_full, ~w_rx_empty};

    always_comb begin
        io_din = 16'h0000;
        if (io_addr[DATA_BIT]) begin
            if (!w_rx_empty)
                io_din = {8'h00, r_rx_mem[r_rx_rp[RX_AW-1:0]]};
        end else if (io_addr[STAT_BIT]) begin
            io_din = w_status;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp[TX_AW-1:0]] <= io_dout[7:0];
        if (w_rx_push)
            r_rx_mem[r_rx_wp[RX_AW-1:0]] <= uart0_data;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state   <= S_IDLE;
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_tx_drop <= 1'b0;
            r_tx_ie   <= 1'b0;
            r_uart_wr <= 1'b0;
            r_uart_w  <= 8'h00;
            r_uart_rd <= 1'b0;
            r_rx_hold <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_flush) begin
                r_tx_wp <= '0;
                r_tx_rp <= '0;
                r_rx_wp <= '0;
                r_rx_rp <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
                if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            end

            if (w_tx_drop)
                r_tx_drop <= 1'b1;
            else if (w_stat_rd)
                r_tx_drop <= 1'b0;

            if (w_stat_wr)
                r_tx_ie <= io_dout[0];

            r_uart_rd <= w_rx_push;
            r_rx_hold <= r_uart_rd;
            r_irq     <= ~w_rx_empty | (r_tx_ie & w_tx_empty);

            // GUARD masks the UART's busy-assert latency
            unique case (r_state)
                S_IDLE: begin
                    if (w_tx_pop) begin
                        r_state   <= S_SEND;
                        r_uart_wr <= 1'b1;
                        r_uart_w  <= r_tx_mem[r_tx_rp[TX_AW-1:0]];
                    end
                end
                S_SEND: begin
                    r_uart_wr <= 1'b0;
                    r_state   <= S_GUARD;
                end
                S_GUARD: r_state <= S_IDLE;
                default: begin
                    r_uart_wr <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign uart0_wr = r_uart_wr;
    assign uart_w   = r_uart_w;
    assign uart0_rd = r_uart_rd;
    assign irq      = r_irq;

    assign w_unused = ^{io_addr, io_dout};

endmodule
